// File: rtl/data_sram_like_slave.sv
// data_sram_like_slave
// Responder for the data-side sram-like bus. Requests are accepted with a
// req/addr_ok handshake into an in-order queue. An internal word RAM backs
// them, and each accepted request gets exactly one data_ok pulse after at
// least LAT cycles. RANDOM=1 adds LFSR-driven accept stalls and response holds.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   req          request valid
//   wr           1 = write, 0 = read
//   size         byte count minus one
//   addr         byte address; word index is addr[ADDR_W+1:2]
//   wdata        write data in byte-lane position
//   addr_ok      request accepted this cycle when req is also high
//   data_ok      one-cycle response pulse, in accept order
//   rdata        read word while data_ok is high, 0 otherwise
module data_sram_like_slave #(
  parameter int          ADDR_W    = 14,
  parameter int          DEPTH     = 4,
  parameter int          LAT       = 1,
  parameter int          RANDOM    = 0,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] FULL    = (PW+1)'(DEPTH);
  localparam logic [3:0]  CD_INIT = 4'(LAT - 1);

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  cd;
  } entry_t;

  logic [31:0]       ram [2**ADDR_W];
  entry_t            q [DEPTH];
  logic [PW-1:0]     head, tail, head_nx;
  logic [PW:0]       count, count_nx, remain;
  logic [15:0]       lfsr;
  logic              stall_r, hold_r, hold_nx;
  logic              accept, pop, dok_nx;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        strb;
  logic [2:0]        lo;
  entry_t            new_ent, head_ent_nx;

  // Address bits above the RAM index wrap and are intentionally ignored.
  wire unused_addr = &{1'b0, addr[31:ADDR_W+2]};

  function automatic logic [3:0] dec(input logic [3:0] c);
    return (c == 4'd0) ? c : c - 4'd1;
  endfunction

  assign idx     = addr[ADDR_W+1:2];
  assign lo      = {1'b0, addr[1:0]};
  // addr_ok looks only at registered state so the master can use it freely.
  assign addr_ok = (count != FULL) && !stall_r;
  assign accept  = req && addr_ok;
  assign pop     = data_ok;

  // Lanes lo..lo+size; lanes past 3 simply do not exist, which clips.
  always_comb begin
    strb = '0;
    for (int i = 0; i < 4; i++)
      strb[i] = (3'(i) >= lo) && (3'(i) <= lo + 3'(size));
  end

  // data_ok/rdata are flops. Their next value is whatever the head entry
  // will look like after this edge. This lets LAT=1 answer in the very next
  // cycle without a combinational path from req.
  always_comb begin
    new_ent.rdata = wr ? 32'h0 : ram[idx];
    new_ent.cd    = CD_INIT;
    count_nx      = count + (PW+1)'(accept) - (PW+1)'(pop);
    remain        = count - (PW+1)'(pop);
    head_nx       = head + PW'(pop);
    hold_nx       = (RANDOM != 0) && lfsr[2] && lfsr[3];
    if (accept && remain == '0) begin
      head_ent_nx = new_ent;
    end else begin
      head_ent_nx.rdata = q[head_nx].rdata;
      head_ent_nx.cd    = dec(q[head_nx].cd);
    end
    dok_nx = (count_nx != '0) && (head_ent_nx.cd == 4'd0) && !hold_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      lfsr    <= SEED;
      stall_r <= 1'b0;
      hold_r  <= 1'b0;
      data_ok <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      head    <= head_nx;
      tail    <= tail + PW'(accept);
      count   <= count_nx;
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      stall_r <= (RANDOM != 0) && lfsr[0] && lfsr[1];
      hold_r  <= hold_nx;
      data_ok <= dok_nx;
      rdata   <= dok_nx ? head_ent_nx.rdata : 32'h0;
    end
  end

  // Entry storage needs no reset: pointers decide which slots are live,
  // and every new entry reloads its countdown.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && tail == PW'(i)) q[i]    <= new_ent;
      else                          q[i].cd <= dec(q[i].cd);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && wr) begin
      for (int l = 0; l < 4; l++)
        if (strb[l]) ram[idx][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

endmodule

// File: tb/tb_data_sram_like_slave.sv
module tb_data_sram_like_slave;
  localparam int N = 4;
  localparam int LATS [N] = '{1, 8, 2, 3};
  localparam int RNDS [N] = '{0, 0, 0, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        req [N];
  logic        wr [N];
  logic [1:0]  size [N];
  logic [31:0] addr [N];
  logic [31:0] wdata [N];
  logic        addr_ok [N];
  logic        data_ok [N];
  logic [31:0] rdata [N];

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int n_acc [N];
  int n_dok [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : gi
    data_sram_like_slave #(
      .ADDR_W(8), .DEPTH(4), .LAT(LATS[g]), .RANDOM(RNDS[g]),
      .SEED(16'hACE1), .INIT_FILE("")
    ) dut (
      .clk(clk), .reset(reset), .req(req[g]), .wr(wr[g]), .size(size[g]),
      .addr(addr[g]), .wdata(wdata[g]), .addr_ok(addr_ok[g]),
      .data_ok(data_ok[g]), .rdata(rdata[g])
    );

    // Reference: byte-addressed memory plus FIFO of expected responses.
    logic [7:0]  bm [1024];
    logic [31:0] exp_q [$];
    int          acc_q [$];

    always @(negedge clk) begin
      logic [31:0] e;
      int a, w, lo, hi;
      if (data_ok[g]) begin
        n_dok[g]++;
        n_chk++;
        assert (exp_q.size() != 0) else begin
          n_fail++; $error("FAIL spurious_data_ok inst %0d: pending %0d, required >0", g, exp_q.size());
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          n_chk++;
          assert (rdata[g] === e) else begin
            n_fail++; $error("FAIL rdata inst %0d: got %h, required %h", g, rdata[g], e);
          end
          n_chk++;
          assert (RNDS[g] != 0 ? (cyc >= a + LATS[g]) : (cyc == a + LATS[g])) else begin
            n_fail++; $error("FAIL latency inst %0d: data_ok at cycle %0d, accept cycle %0d, LAT %0d", g, cyc, a, LATS[g]);
          end
        end
      end
      if (reset) begin
        exp_q.delete();
        acc_q.delete();
      end else if (req[g] && addr_ok[g]) begin
        w = int'(addr[g][9:2]);
        exp_q.push_back(wr[g] ? 32'h0 : {bm[w*4+3], bm[w*4+2], bm[w*4+1], bm[w*4]});
        acc_q.push_back(cyc);
        if (wr[g]) begin
          lo = int'(addr[g][1:0]);
          hi = lo + int'(size[g]);
          for (int l = 0; l < 4; l++)
            if (l >= lo && l <= hi) bm[w*4+l] = wdata[g][8*l +: 8];
        end
        n_acc[g]++;
      end
    end
  end

  task automatic issue(input int i, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    req[i] = 1'b1; wr[i] = w; size[i] = s; addr[i] = a; wdata[i] = d;
    do begin @(negedge clk); t++; end while (!addr_ok[i] && t < 100);
    n_chk++;
    assert (addr_ok[i] === 1'b1) else begin
      n_fail++; $error("FAIL accept_timeout inst %0d: addr_ok %b, required 1", i, addr_ok[i]);
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic wait_dok(input int i, output logic [31:0] d);
    int t = 0;
    do begin @(negedge clk); t++; end while (!data_ok[i] && t < 100);
    n_chk++;
    assert (data_ok[i] === 1'b1) else begin
      n_fail++; $error("FAIL data_ok_timeout inst %0d: data_ok %b, required 1", i, data_ok[i]);
    end
    d = rdata[i];
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++; $error("FAIL %s: got %h, required %h", tag, got, want);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic prev;
    int t;
    for (int i = 0; i < N; i++) begin
      req[i] = 0; wr[i] = 0; size[i] = 0; addr[i] = 0; wdata[i] = 0;
      n_acc[i] = 0; n_dok[i] = 0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, first cycle after reset.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_addr_ok", 32'(addr_ok[i]), 32'd1);
      check("reset_data_ok", 32'(data_ok[i]), 32'd0);
      check("reset_rdata", rdata[i], 32'h0);
    end
    @(posedge clk); #1;

    // LAT=1: full word, byte and halfword merges, clipping, address wrap.
    issue(0, 1, 3, 32'h100, 32'h11223344); wait_dok(0, d); check("write_rdata", d, 32'h0);
    issue(0, 0, 3, 32'h100, 32'h0);        wait_dok(0, d); check("read_full", d, 32'h11223344);
    issue(0, 1, 0, 32'h101, 32'h0000AA00); wait_dok(0, d);
    issue(0, 0, 3, 32'h100, 32'h0);        wait_dok(0, d); check("read_byte", d, 32'h1122AA44);
    issue(0, 1, 1, 32'h102, 32'hBEEF0000); wait_dok(0, d);
    issue(0, 0, 0, 32'h100, 32'h0);        wait_dok(0, d); check("read_half", d, 32'hBEEFAA44);
    issue(0, 1, 3, 32'h104, 32'h55667788); wait_dok(0, d);
    issue(0, 1, 3, 32'h108, 32'h01020304); wait_dok(0, d);
    issue(0, 1, 3, 32'h106, 32'hCAFE0000); wait_dok(0, d);
    issue(0, 0, 3, 32'h104, 32'h0);        wait_dok(0, d); check("clip_lanes", d, 32'hCAFE7788);
    issue(0, 0, 3, 32'h108, 32'h0);        wait_dok(0, d); check("clip_no_spill", d, 32'h01020304);
    issue(0, 1, 3, 32'hFFFF_F500, 32'hDEADBEEF); wait_dok(0, d);
    issue(0, 0, 3, 32'h100, 32'h0);        wait_dok(0, d); check("addr_wrap", d, 32'hDEADBEEF);

    // LAT=8: fill the queue, verify full and that a pop reopens it.
    for (int k = 0; k < 6; k++) issue(1, 1, 3, 32'(k*4), 32'hA5A50000 + 32'(k));
    repeat (12) @(posedge clk); #1;
    for (int k = 0; k < 4; k++) issue(1, 0, 3, 32'(k*4), 32'h0);
    @(negedge clk);
    check("full_addr_ok", 32'(addr_ok[1]), 32'd0);
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h10;
    prev = 1'b0; t = 0;
    while (t < 20) begin
      @(negedge clk); t++;
      if (addr_ok[1]) break;
      prev = data_ok[1];
    end
    check("reopen_addr_ok", 32'(addr_ok[1]), 32'd1);
    check("reopen_after_pop", 32'(prev), 32'd1);
    @(posedge clk); #1;
    issue(1, 0, 3, 32'h14, 32'h0);
    repeat (12) @(posedge clk); #1;

    // Reset with three requests in flight.
    for (int k = 0; k < 3; k++) issue(1, 0, 3, 32'(k*4), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_addr_ok", 32'(addr_ok[1]), 32'd1);
    for (int k = 0; k < 12; k++) begin
      check("post_reset_data_ok", 32'(data_ok[1]), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    issue(1, 0, 3, 32'h0, 32'h0); wait_dok(1, d); check("post_reset_read", d, 32'hA5A50000);

    // LAT=2 steady stream: one accept per cycle, addr_ok never drops.
    for (int k = 0; k < 20; k++) begin
      req[2] = 1'b1; wr[2] = (k < 10); size[2] = 2'd3;
      addr[2] = 32'h200 + 32'((k % 10) * 4); wdata[2] = $urandom;
      @(negedge clk);
      check("stream_addr_ok", 32'(addr_ok[2]), 32'd1);
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("stream_accepts", 32'(n_acc[2]), 32'd20);
    check("stream_responses", 32'(n_dok[2]), 32'd20);

    // RANDOM=1: preload 16 words, then random traffic with wrapped upper bits.
    for (int k = 0; k < 16; k++) issue(3, 1, 3, 32'(k*4), $urandom);
    for (int k = 0; k < 2000; k++) begin
      issue(3, 1'($urandom % 2), 2'($urandom % 4),
            ($urandom & 32'hFFFF_FC00) | (($urandom % 16) << 2) | ($urandom % 4),
            $urandom);
      if ($urandom % 4 == 0) begin @(posedge clk); #1; end
    end
    t = 0;
    while (n_dok[3] != n_acc[3] && t < 500) begin @(negedge clk); t++; end
    check("random_accepts", 32'(n_acc[3]), 32'd2016);
    check("random_responses", 32'(n_dok[3]), 32'(n_acc[3]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
